// File: rtl/pipeline_ctrl_if.sv
// Sequencing-controller bus: global advance/mode qualifiers and decode-stage
// events in, per-latch strobes, debug counters and state out.
interface pipeline_ctrl_if #(
  parameter int unsigned N_STAGES = 5,
  parameter int unsigned NB_CNT   = 32,
  parameter int unsigned NB_STATE = 2
);
  logic                i_valid;
  logic                i_mode;
  logic                i_step;
  logic                i_hazard;
  logic                i_redirect;
  logic                i_halt_instr;
  logic [N_STAGES-1:0] o_stage_en;
  logic [N_STAGES-1:0] o_stage_flush;
  logic [NB_CNT-1:0]   o_n_clocks;
  logic [NB_CNT-1:0]   o_n_stalls;
  logic                o_halted;
  logic [NB_STATE-1:0] o_state;

  // Core/debug side driving the controller
  modport master (
    output i_valid, i_mode, i_step, i_hazard, i_redirect, i_halt_instr,
    input  o_stage_en, o_stage_flush, o_n_clocks, o_n_stalls, o_halted, o_state
  );

  // Controller side
  modport slave (
    input  i_valid, i_mode, i_step, i_hazard, i_redirect, i_halt_instr,
    output o_stage_en, o_stage_flush, o_n_clocks, o_n_stalls, o_halted, o_state
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: per-latch enable/flush generation for the
// N-stage core with run/single-step modes, load-use stalls, redirect flush,
// halt-and-drain, and saturating cycle/stall counters for debug.
module pipeline_ctrl #(
  parameter int unsigned N_STAGES = 5,
  parameter int unsigned NB_CNT   = 32,
  parameter int unsigned NB_STATE = 2
) (
  input logic             i_clock,
  input logic             i_reset,
  pipeline_ctrl_if.slave  bus
);

  localparam int unsigned NB_DCNT = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [N_STAGES-1:0] EN_ALL    = '1;
  localparam logic [N_STAGES-1:0] EN_BUBBLE = {{(N_STAGES-2){1'b1}}, 2'b00};
  localparam logic [N_STAGES-1:0] FL_IFID   = N_STAGES'(2);
  localparam logic [N_STAGES-1:0] FL_IDEX   = N_STAGES'(4);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t               state, state_n;
  logic                 drain, drain_n;
  logic [NB_DCNT-1:0]   dcnt, dcnt_n;
  logic [NB_CNT-1:0]    n_clocks, n_stalls;
  logic                 adv, stall;
  logic [N_STAGES-1:0]  en, flush;

  // Next-state, advance qualification and per-latch strobe decode
  always_comb begin
    state_n = state;
    drain_n = drain;
    dcnt_n  = dcnt;
    adv     = 1'b0;
    stall   = 1'b0;
    en      = '0;
    flush   = '0;

    case (state)
      S_IDLE:   if (bus.i_valid) state_n = bus.i_mode ? S_STEP : S_RUN;
      S_RUN:    if (bus.i_mode) state_n = S_STEP;
                else adv = bus.i_valid;
      S_STEP:   if (!bus.i_mode) state_n = S_RUN;
                else adv = bus.i_valid & bus.i_step;
      S_HALTED: ;
      default:  state_n = S_IDLE;
    endcase

    if (adv) begin
      if (drain) begin
        // Drain ignores decode events; the front latches stay frozen
        en     = EN_BUBBLE;
        flush  = FL_IDEX;
        dcnt_n = dcnt - NB_DCNT'(1);
        if (dcnt == NB_DCNT'(1)) state_n = S_HALTED;
      end else if (bus.i_halt_instr) begin
        en      = EN_BUBBLE;
        flush   = FL_IDEX;
        drain_n = 1'b1;
        dcnt_n  = NB_DCNT'(N_STAGES - 2);
      end else if (bus.i_hazard) begin
        // Redirect is dropped here: decode re-evaluates next cycle
        en    = EN_BUBBLE;
        flush = FL_IDEX;
        stall = 1'b1;
      end else if (bus.i_redirect) begin
        en    = EN_ALL;
        flush = FL_IFID;
      end else begin
        en = EN_ALL;
      end
    end

    if (i_reset) begin
      en    = '0;
      flush = '0;
    end
  end

  // State, drain tracking and saturating counters
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= S_IDLE;
      drain    <= 1'b0;
      dcnt     <= '0;
      n_clocks <= '0;
      n_stalls <= '0;
    end else begin
      state <= state_n;
      drain <= drain_n;
      dcnt  <= dcnt_n;
      if (adv && (n_clocks != '1)) n_clocks <= n_clocks + NB_CNT'(1);
      if (stall && (n_stalls != '1)) n_stalls <= n_stalls + NB_CNT'(1);
    end
  end

  assign bus.o_stage_en    = en;
  assign bus.o_stage_flush = flush;
  assign bus.o_n_clocks    = n_clocks;
  assign bus.o_n_stalls    = n_stalls;
  assign bus.o_halted      = (state == S_HALTED);
  assign bus.o_state       = NB_STATE'(state);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (5 stages/32-bit counters and
// 6 stages/4-bit counters) share stimulus; directed table, hand sequences
// and random traffic checked against a behavioural model.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst, valid, mode, step, hazard, redirect, halt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.N_STAGES(5), .NB_CNT(32), .NB_STATE(2)) bus5 ();
  pipeline_ctrl_if #(.N_STAGES(6), .NB_CNT(4),  .NB_STATE(2)) bus6 ();

  assign bus5.i_valid = valid;    assign bus6.i_valid = valid;
  assign bus5.i_mode = mode;      assign bus6.i_mode = mode;
  assign bus5.i_step = step;      assign bus6.i_step = step;
  assign bus5.i_hazard = hazard;  assign bus6.i_hazard = hazard;
  assign bus5.i_redirect = redirect; assign bus6.i_redirect = redirect;
  assign bus5.i_halt_instr = halt;   assign bus6.i_halt_instr = halt;

  pipeline_ctrl #(.N_STAGES(5), .NB_CNT(32), .NB_STATE(2)) u_dut5 (
    .i_clock(clk), .i_reset(rst), .bus(bus5.slave)
  );
  pipeline_ctrl #(.N_STAGES(6), .NB_CNT(4), .NB_STATE(2)) u_dut6 (
    .i_clock(clk), .i_reset(rst), .bus(bus6.slave)
  );

  // Behavioural model: phase 0 idle, 1 run, 2 step, 3 halted;
  // m_left = drain advances still owed before halting.
  int     m_st[2], m_left[2];
  bit     m_dr[2];
  longint m_clk[2], m_stl[2];
  int     m_n[2]  = '{5, 6};
  int     m_nb[2] = '{32, 4};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_left[k] = 0; m_dr[k] = 0; m_clk[k] = 0; m_stl[k] = 0;
    end
  endtask

  task automatic model_check(input int k);
    logic [7:0]  a_en, a_fl, e_en, e_fl, all_m, bub;
    logic [1:0]  a_st;
    logic        a_h;
    logic [63:0] a_c, a_s;
    longint      mx;
    bit          adv;
    int          nst;
    if (k == 0) begin
      a_en = 8'(bus5.o_stage_en); a_fl = 8'(bus5.o_stage_flush);
      a_st = bus5.o_state; a_h = bus5.o_halted;
      a_c = 64'(bus5.o_n_clocks); a_s = 64'(bus5.o_n_stalls);
    end else begin
      a_en = 8'(bus6.o_stage_en); a_fl = 8'(bus6.o_stage_flush);
      a_st = bus6.o_state; a_h = bus6.o_halted;
      a_c = 64'(bus6.o_n_clocks); a_s = 64'(bus6.o_n_stalls);
    end
    all_m = 8'((1 << m_n[k]) - 1);
    bub   = all_m & 8'hFC;
    mx    = (longint'(1) << m_nb[k]) - 1;

    check($sformatf("state%0d", m_n[k]), 64'(a_st), 64'(m_st[k]));
    check($sformatf("halted%0d", m_n[k]), 64'(a_h), 64'(m_st[k] == 3));
    check($sformatf("clocks%0d", m_n[k]), a_c, m_clk[k]);
    check($sformatf("stalls%0d", m_n[k]), a_s, m_stl[k]);

    e_en = '0; e_fl = '0;
    if (rst) begin
      m_st[k] = 0; m_left[k] = 0; m_dr[k] = 0; m_clk[k] = 0; m_stl[k] = 0;
    end else begin
      adv = 0;
      nst = m_st[k];
      case (m_st[k])
        0: if (valid) nst = mode ? 2 : 1;
        1: if (mode) nst = 2; else adv = valid;
        2: if (!mode) nst = 1; else adv = valid && step;
        default: ;
      endcase
      if (adv) begin
        m_clk[k] = (m_clk[k] + 1 > mx) ? mx : m_clk[k] + 1;
        if (m_dr[k]) begin
          e_en = bub; e_fl = 8'h04;
          m_left[k]--;
          if (m_left[k] == 0) nst = 3;
        end else if (halt) begin
          e_en = bub; e_fl = 8'h04;
          m_dr[k] = 1; m_left[k] = m_n[k] - 2;
        end else if (hazard) begin
          e_en = bub; e_fl = 8'h04;
          m_stl[k] = (m_stl[k] + 1 > mx) ? mx : m_stl[k] + 1;
        end else if (redirect) begin
          e_en = all_m; e_fl = 8'h02;
        end else begin
          e_en = all_m;
        end
      end
      m_st[k] = nst;
    end
    check($sformatf("en%0d", m_n[k]), 64'(a_en), 64'(e_en));
    check($sformatf("flush%0d", m_n[k]), 64'(a_fl), 64'(e_fl));
  endtask

  task automatic drive(input bit r, v, m, s, hz, rd, h);
    rst = r; valid = v; mode = m; step = s; hazard = hz; redirect = rd; halt = h;
  endtask

  // Inputs are applied at the falling edge; sample 2 time units later.
  task automatic settle();
    #2;
    model_check(0);
    model_check(1);
  endtask

  task automatic next_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit         rst, valid, mode, step, hazard, redirect, halt;
    logic [4:0] en, fl;
    logic [1:0] st;
    int         clks, stls;
  } vec_t;

  function automatic vec_t mk(bit r, v, m, s, hz, rd, h,
                              logic [4:0] en, fl, logic [1:0] st, int c, int sl);
    vec_t t;
    t.rst = r; t.valid = v; t.mode = m; t.step = s; t.hazard = hz;
    t.redirect = rd; t.halt = h; t.en = en; t.fl = fl; t.st = st;
    t.clks = c; t.stls = sl;
    return t;
  endfunction

  vec_t tbl[27];
  int   cnt_adv, n5, n6;

  initial begin
    // Expected values for the 5-stage instance, sampled before each edge
    tbl[0]  = mk(1,0,0,0,0,0,0, 5'h00,5'h00,2'd0, 0,0);
    tbl[1]  = mk(0,1,0,0,0,0,0, 5'h00,5'h00,2'd0, 0,0);
    tbl[2]  = mk(0,1,0,0,0,0,0, 5'h1F,5'h00,2'd1, 0,0);
    tbl[3]  = mk(0,1,0,0,0,0,0, 5'h1F,5'h00,2'd1, 1,0);
    tbl[4]  = mk(0,1,0,0,1,0,0, 5'h1C,5'h04,2'd1, 2,0);
    tbl[5]  = mk(0,1,0,0,1,1,0, 5'h1C,5'h04,2'd1, 3,1);
    tbl[6]  = mk(0,1,0,0,0,1,0, 5'h1F,5'h02,2'd1, 4,2);
    tbl[7]  = mk(0,0,0,0,0,0,0, 5'h00,5'h00,2'd1, 5,2);
    tbl[8]  = mk(0,1,1,0,0,0,0, 5'h00,5'h00,2'd1, 5,2);
    tbl[9]  = mk(0,1,1,0,0,0,0, 5'h00,5'h00,2'd2, 5,2);
    tbl[10] = mk(0,1,1,1,0,0,0, 5'h1F,5'h00,2'd2, 5,2);
    tbl[11] = mk(0,1,1,0,0,0,0, 5'h00,5'h00,2'd2, 6,2);
    tbl[12] = mk(0,0,1,1,0,0,0, 5'h00,5'h00,2'd2, 6,2);
    tbl[13] = mk(0,1,1,1,0,0,1, 5'h1C,5'h04,2'd2, 6,2);
    tbl[14] = mk(0,1,1,0,1,0,0, 5'h00,5'h00,2'd2, 7,2);
    tbl[15] = mk(0,1,0,0,0,0,0, 5'h00,5'h00,2'd2, 7,2);
    tbl[16] = mk(0,1,0,0,0,1,0, 5'h1C,5'h04,2'd1, 7,2);
    tbl[17] = mk(0,1,0,0,0,0,0, 5'h1C,5'h04,2'd1, 8,2);
    tbl[18] = mk(0,1,0,0,0,0,1, 5'h1C,5'h04,2'd1, 9,2);
    tbl[19] = mk(0,1,1,1,1,0,0, 5'h00,5'h00,2'd3,10,2);
    tbl[20] = mk(1,1,0,0,0,0,0, 5'h00,5'h00,2'd3,10,2);
    tbl[21] = mk(0,0,0,0,0,0,0, 5'h00,5'h00,2'd0, 0,0);
    tbl[22] = mk(0,1,0,0,0,0,0, 5'h00,5'h00,2'd0, 0,0);
    tbl[23] = mk(0,1,0,0,0,0,1, 5'h1C,5'h04,2'd1, 0,0);
    tbl[24] = mk(0,1,0,0,0,0,0, 5'h1C,5'h04,2'd1, 1,0);
    tbl[25] = mk(1,1,0,0,0,0,0, 5'h00,5'h00,2'd1, 2,0);
    tbl[26] = mk(0,0,0,0,0,0,0, 5'h00,5'h00,2'd0, 0,0);

    drive(1,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].rst, tbl[i].valid, tbl[i].mode, tbl[i].step,
            tbl[i].hazard, tbl[i].redirect, tbl[i].halt);
      settle();
      check($sformatf("tbl%0d_en", i), 64'(bus5.o_stage_en), 64'(tbl[i].en));
      check($sformatf("tbl%0d_flush", i), 64'(bus5.o_stage_flush), 64'(tbl[i].fl));
      check($sformatf("tbl%0d_state", i), 64'(bus5.o_state), 64'(tbl[i].st));
      check($sformatf("tbl%0d_clocks", i), 64'(bus5.o_n_clocks), 64'(tbl[i].clks));
      check($sformatf("tbl%0d_stalls", i), 64'(bus5.o_n_stalls), 64'(tbl[i].stls));
      next_edge();
    end

    // Continuous run: 11 cycles -> 1 idle + 10 full advances
    drive(1,0,0,0,0,0,0); settle(); next_edge();
    cnt_adv = 0;
    for (int i = 0; i < 11; i++) begin
      drive(0,1,0,0,0,0,0); settle();
      if (bus5.o_stage_en == 5'h1F && bus5.o_stage_flush == 5'h00) cnt_adv++;
      next_edge();
    end
    check("run_adv_cycles", 64'(cnt_adv), 64'd10);
    check("run_clocks", 64'(bus5.o_n_clocks), 64'd10);
    check("run_state", 64'(bus5.o_state), 64'd1);

    // Saturation of the 4-bit counter after 21 advances
    for (int i = 0; i < 11; i++) begin
      drive(0,1,0,0,0,0,0); settle(); next_edge();
    end
    check("sat_clocks5", 64'(bus5.o_n_clocks), 64'd21);
    check("sat_clocks6", 64'(bus6.o_n_clocks), 64'd15);

    // Halt then count drain cycles per depth (bounded wait)
    drive(0,1,0,0,0,0,1); settle(); next_edge();
    n5 = -1; n6 = -1;
    for (int i = 0; i < 20; i++) begin
      drive(0,1,0,1,1,0,0); settle();
      if (n5 < 0 && bus5.o_halted) n5 = i;
      if (n6 < 0 && bus6.o_halted) n6 = i;
      if (n5 >= 0 && n6 >= 0) break;
      next_edge();
    end
    check("drain_len5", 64'(n5), 64'd3);
    check("drain_len6", 64'(n6), 64'd4);
    next_edge();

    // Single-step: 3 pulses over 20 cycles, plus a step with valid low
    drive(1,0,1,0,0,0,0); settle(); next_edge();
    cnt_adv = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, (i != 17), 1, (i == 3 || i == 8 || i == 14 || i == 17), 0, 0, 0);
      settle();
      if (bus5.o_stage_en == 5'h1F) cnt_adv++;
      next_edge();
    end
    check("step_adv_cycles", 64'(cnt_adv), 64'd3);
    check("step_clocks", 64'(bus5.o_n_clocks), 64'd3);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29) == 0) mode = ~mode;
      drive(($urandom_range(99) == 0), ($urandom_range(9) != 0), mode,
            ($urandom_range(2) == 0), ($urandom_range(4) == 0),
            ($urandom_range(4) == 0), ($urandom_range(49) == 0));
      settle();
      next_edge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
